// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle shared between the requesters and the round-robin arbiter.
// The master drives requests and completion; the slave (arbiter) drives grants.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot and binary grant outputs.
// A grant is held until done, request drop, or the optional hold limit expires.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    rr_arbiter8_if.slave     bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t     state_reg, state_next;
    logic [2:0] ptr_reg, ptr_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [7:0] gnt_reg, gnt_next;
    logic [2:0] idx_reg, idx_next;
    logic       valid_reg, valid_next;
    logic       timeout_reg, timeout_next;

    logic [2:0] cand [8];
    logic [2:0] sel_idx;
    logic [7:0] sel_onehot;
    logic       hold_expired;

    // Candidate k is the requester k places above the priority pointer.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cand
            assign cand[gi]       = ptr_reg + 3'(gi);
            assign sel_onehot[gi] = (sel_idx == 3'(gi));
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest set request wins.
    always_comb begin
        sel_idx = ptr_reg;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[cand[k]]) begin
                sel_idx = cand[k];
            end
        end
    end

    assign hold_expired = (HOLD_LIM != 8'd0) && (cnt_reg == HOLD_LIM);

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        cnt_next     = cnt_reg;
        gnt_next     = gnt_reg;
        idx_next     = idx_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.req != 8'h00) begin
                    idx_next   = sel_idx;
                    gnt_next   = sel_onehot;
                    valid_next = 1'b1;
                    cnt_next   = 8'd1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (bus.done || !bus.req[idx_reg] || hold_expired) begin
                    // done outranks the limit, so a tie never flags a timeout.
                    timeout_next = !bus.done && bus.req[idx_reg] && hold_expired;
                    gnt_next     = 8'h00;
                    valid_next   = 1'b0;
                    ptr_next     = idx_reg + 3'd1;
                    state_next   = IDLE;
                end else if (cnt_reg != 8'hFF) begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= 3'd0;
            cnt_reg     <= 8'd0;
            gnt_reg     <= 8'h00;
            idx_reg     <= 3'd0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            gnt_reg     <= gnt_next;
            idx_reg     <= idx_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_idx   = idx_reg;
    assign bus.gnt_valid = valid_reg;
    assign bus.timeout   = timeout_reg;

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one decoded resource slot among eight requesters. It accepts a request vector, selects one requester fairly, and drives both a 3-bit binary grant index and its one-hot decode. Bit `i` of the one-hot output is asserted for index `i`, with index bit 2 as MSB, matching the team's 3-to-8 decoder output ordering. Each grant is held until the owner signals completion, drops its request, or exceeds a configurable hold limit.

## Interface
- `HOLD_MAX`, default 15: maximum cycles one grant may be held; legal range 0..255; 0 = unlimited.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `req`  in  8  request vector; `req[i]` high = requester i wants the resource.
- `done`  in  1  current owner finished; sampled only in GRANT.
- `gnt`  out  8  one-hot grant; all zero when no grant is active.
- `gnt_idx`  out  3  binary index of the current owner; holds its last value when idle.
- `gnt_valid`  out  1  a grant is active; equals `|gnt`.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by `HOLD_MAX`.

## Operation
- All outputs are registered.
- State machine: IDLE and GRANT.
- Internal state:
  - `ptr` (3 bits): the highest-priority index.
  - `cnt` (8 bits): the hold counter.
- Reset (`rst` high at a clock edge):
  - state = IDLE, `ptr` = 0, `cnt` = 0.
  - `gnt` = 8'h00, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0.
  - `rst` overrides every other input.
- IDLE:
  - If `req` is 0, remain in IDLE.
  - Otherwise, select the first set `req` bit searching upward from `ptr`, wrapping 7→0.
  - Load `gnt_idx` with that index and `gnt` with its one-hot decode; set `gnt_valid`=1 and `cnt`=1; go to GRANT.
- GRANT, release conditions in priority order:
  1. `done`=1.
  2. `req[gnt_idx]`=0.
  3. `HOLD_MAX`≠0 and `cnt`==`HOLD_MAX`; this sets `timeout`=1 for the next cycle.
- On release:
  - Clear `gnt` and `gnt_valid`; `gnt_idx` keeps its value.
  - `ptr` = `gnt_idx`+1 mod 8 (7 wraps to 0).
  - Go to IDLE.
- Otherwise, stay in GRANT.
  - `cnt` increments, saturating at 255.
  - If `HOLD_MAX`=0, `cnt` is compared against nothing.
- `done` and the timeout condition in the same cycle: `done` wins and `timeout` stays 0.
- In GRANT, `req` bits of non-owners are ignored. A new request is considered only at the next IDLE evaluation.
- `done` is ignored in IDLE.
- `timeout` is high only in the first IDLE cycle after a timeout release; it is 0 otherwise.
- The revoked requester is re-arbitrated normally, with the lowest priority because `ptr` has moved past it.

## Timing
- Grant latency: `req` set in the cycle before edge N → `gnt` valid after edge N. With a held request this is 1 cycle.
- Release latency: a release condition sampled at edge M → `gnt` is 0 after edge M.
- Every release is followed by at least one IDLE cycle with `gnt`=0. This guarantees no two grants overlap or abut.
- Back-to-back grants to different requesters are separated by exactly one idle cycle when requests are pending.
- Maximum grant length with `HOLD_MAX`=H>0: H cycles of `gnt_valid`=1.
- Worst-case wait for a continuously requesting requester: 7 grants of other requesters.
- Reset mid-grant: `gnt` is 0 after the reset edge. The next grant is evaluated from `ptr`=0 in the first cycle with `rst` low.

## Test plan
- Reset then single requester:
  - Stimulus: `rst` 2 cycles; `req`=8'h08 held; `done` pulsed on the 4th grant cycle.
  - Response: after the first edge with `rst` low, `gnt`=8'h08, `gnt_idx`=3, `gnt_valid`=1 for 4 cycles; then `gnt`=0 and `ptr`=4.
- Round-robin fairness:
  - Stimulus: `req`=8'hFF constant; `done` pulsed on each grant's first cycle.
  - Response: `gnt_idx` sequence 0,1,2,…,7,0; each grant is 1 cycle followed by 1 idle cycle.
- Wrap-around:
  - Stimulus: `ptr`=6 (reach it by granting then releasing index 5); `req`=8'h03.
  - Response: `gnt_idx`=0 first, then 1 after release.
- Timeout:
  - Stimulus: `HOLD_MAX`=4; `req`=8'h80 held; `done`=0.
  - Response: `gnt`=8'h80 for exactly 4 cycles; then `gnt`=0 and `timeout`=1 for 1 cycle; then re-granted to index 7.
- Done/timeout tie and request drop:
  - Tie stimulus: `done`=1 in the 4th cycle with `HOLD_MAX`=4. Response: `timeout` stays 0.
  - Drop stimulus: `req[2]` drops mid-grant. Response: `gnt` is 0 next cycle.
- Reset mid-grant:
  - Stimulus: `rst` asserted while `gnt`=8'h20.
  - Response: `gnt`=0, `gnt_idx`=0, `timeout`=0 after the edge; with `req`=8'h21, the next grant is index 0.
